board_io_bridge: RTL and testbench

BOARD_IO_BRIDGE -- requirements
Module: board_io_bridge

---
 rtl/board_io_pkg.sv | 39 +++
 rtl/debounce_fsm.sv | 74 +++++++
 rtl/board_io_bridge.sv | 158 +++++++++++++++
 tb/tb_board_io_bridge.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/board_io_pkg.sv
// Shared definitions for the board I/O bridge.
//   db_state_e : debounce FSM state encoding
//   SEG_BLANK  : all segments off (active-low)
//   hex_to_seg : hex nibble -> active-low 7-segment pattern {g,f,e,d,c,b,a}
package board_io_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CHK_PRESS = 2'd1,
    HELD      = 2'd2,
    CHK_REL   = 2'd3
  } db_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/debounce_fsm.sv
// Button debouncer: accepts a level change only after DB_CYCLES consecutive
// agreeing synchronized samples.
//   clk, reset   : clock, asynchronous active-high reset
//   i_sync       : already-synchronized button level
//   o_press_evt  : one-cycle strobe when a press is accepted (none on release)
module debounce_fsm
  import board_io_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_sync,
  output logic o_press_evt
);

  localparam int unsigned CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  if (DB_CYCLES < 1) begin : g_chk_db
    $error("DB_CYCLES must be at least 1");
  end

  db_state_e       r_state;
  logic [CW-1:0]   r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_sync) begin
            r_state <= CHK_PRESS;
            r_cnt   <= '0;
          end
        end
        CHK_PRESS: begin
          if (!i_sync) begin
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
            if (r_cnt == CNT_LAST) r_state <= HELD;
          end
        end
        HELD: begin
          if (!i_sync) begin
            r_state <= CHK_REL;
            r_cnt   <= '0;
          end
        end
        CHK_REL: begin
          if (i_sync) begin
            r_state <= HELD;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
            if (r_cnt == CNT_LAST) r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Asserted in the cycle whose edge moves the counter to DB_CYCLES, so the
  // consumer can capture on the same edge that enters HELD.
  assign o_press_evt = (r_state == CHK_PRESS) && i_sync && (r_cnt == CNT_LAST);

endmodule

// File: rtl/board_io_bridge.sv
// Board I/O bridge: synchronizes switches/buttons into CPU input ports and
// scans a multiplexed 7-segment display.
//   clk, reset  : clock, asynchronous active-high reset
//   sw          : raw switches, channel k at [k*IN_W +: IN_W]
//   btn_load    : raw bouncing load button (strobed capture)
//   cap_mode    : 0 continuous capture, 1 strobed capture
//   port_in     : registered zero-extended channels, channel k at [k*PORT_W +: PORT_W]
//   load_pulse  : one-cycle strobe aligned with each port_in update
//   disp_val    : display nibbles, digit d at [d*4 +: 4]
//   seg, an     : active-low segments {g,f,e,d,c,b,a} and one-cold digit enables
module board_io_bridge
  import board_io_pkg::*;
#(
  parameter int unsigned NUM_IN      = 3,
  parameter int unsigned IN_W        = 4,
  parameter int unsigned PORT_W      = 8,
  parameter int unsigned NUM_DIG     = 4,
  parameter int unsigned DB_CYCLES   = 16,
  parameter int unsigned REFRESH_DIV = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_IN*IN_W-1:0]     sw,
  input  logic                       btn_load,
  input  logic                       cap_mode,
  output logic [NUM_IN*PORT_W-1:0]   port_in,
  output logic                       load_pulse,
  input  logic [NUM_DIG*4-1:0]       disp_val,
  output logic [6:0]                 seg,
  output logic [NUM_DIG-1:0]         an
);

  if (IN_W > PORT_W) begin : g_chk_width
    $error("IN_W must not exceed PORT_W");
  end

  localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IW = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIG - 1);
  localparam logic [PW-1:0] PRE_ONE  = PW'(1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [NUM_DIG-1:0] AN_RESET = ~NUM_DIG'(1);

  // Two-flop synchronizers
  logic [NUM_IN*IN_W-1:0] r_sw_s1, r_sw_s2;
  logic                   r_btn_s1, r_btn_s2;
  logic                   r_mode_s1, r_mode_s2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sw_s1   <= '0;
      r_sw_s2   <= '0;
      r_btn_s1  <= 1'b0;
      r_btn_s2  <= 1'b0;
      r_mode_s1 <= 1'b0;
      r_mode_s2 <= 1'b0;
    end else begin
      r_sw_s1   <= sw;
      r_sw_s2   <= r_sw_s1;
      r_btn_s1  <= btn_load;
      r_btn_s2  <= r_btn_s1;
      r_mode_s1 <= cap_mode;
      r_mode_s2 <= r_mode_s1;
    end
  end

  logic w_press_evt;

  debounce_fsm #(
    .DB_CYCLES(DB_CYCLES)
  ) u_debounce (
    .clk         (clk),
    .reset       (reset),
    .i_sync      (r_btn_s2),
    .o_press_evt (w_press_evt)
  );

  // Zero-extend each channel into its CPU port slot
  logic [NUM_IN*PORT_W-1:0] w_zext;

  always_comb begin
    w_zext = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      w_zext[k*PORT_W +: IN_W] = r_sw_s2[k*IN_W +: IN_W];
    end
  end

  logic [NUM_IN*PORT_W-1:0] r_port_in;
  logic                     r_load_pulse;

  // The debouncer keeps running in continuous mode; its events are simply
  // not consulted there.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_port_in    <= '0;
      r_load_pulse <= 1'b0;
    end else if (!r_mode_s2) begin
      r_port_in    <= w_zext;
      r_load_pulse <= (w_zext != r_port_in);
    end else begin
      r_load_pulse <= w_press_evt;
      if (w_press_evt) r_port_in <= w_zext;
    end
  end

  assign port_in    = r_port_in;
  assign load_pulse = r_load_pulse;

  // Display scan
  logic [PW-1:0]      r_pre;
  logic [IW-1:0]      r_idx;
  logic [NUM_DIG-1:0] r_an;
  logic [6:0]         r_seg;
  logic               w_pre_wrap;
  logic [IW-1:0]      w_idx_nxt;
  logic [3:0]         w_nib_nxt;
  logic [NUM_DIG-1:0] w_an_nxt;

  assign w_pre_wrap = (r_pre == PRE_LAST);

  always_comb begin
    w_idx_nxt = r_idx;
    if (w_pre_wrap) begin
      w_idx_nxt = (r_idx == IDX_LAST) ? '0 : r_idx + IDX_ONE;
    end
  end

  // an and seg are both registered from the next index so they change together
  always_comb begin
    w_nib_nxt = disp_val[3:0];
    w_an_nxt  = '1;
    for (int unsigned d = 0; d < NUM_DIG; d++) begin
      if (IW'(d) == w_idx_nxt) begin
        w_nib_nxt   = disp_val[d*4 +: 4];
        w_an_nxt[d] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pre <= '0;
      r_idx <= '0;
      r_an  <= AN_RESET;
      r_seg <= SEG_BLANK;
    end else begin
      r_pre <= w_pre_wrap ? '0 : r_pre + PRE_ONE;
      r_idx <= w_idx_nxt;
      r_an  <= w_an_nxt;
      r_seg <= hex_to_seg(w_nib_nxt);
    end
  end

  assign an  = r_an;
  assign seg = r_seg;

endmodule

// File: tb/tb_board_io_bridge.sv
// Scoreboard bench for board_io_bridge (DB_CYCLES=4, REFRESH_DIV=4).
module tb_board_io_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] sw;
  logic        btn_load;
  logic        cap_mode;
  logic [23:0] port_in;
  logic        load_pulse;
  logic [15:0] disp_val;
  logic [6:0]  seg;
  logic [3:0]  an;

  board_io_bridge #(
    .NUM_IN(3), .IN_W(4), .PORT_W(8), .NUM_DIG(4),
    .DB_CYCLES(4), .REFRESH_DIV(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sw         (sw),
    .btn_load   (btn_load),
    .cap_mode   (cap_mode),
    .port_in    (port_in),
    .load_pulse (load_pulse),
    .disp_val   (disp_val),
    .seg        (seg),
    .an         (an)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [23:0] val;
    int          at;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  logic [3:0] AN_EXP  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0] SEG_EXP [4] = '{7'h40, 7'h79, 7'h00, 7'h0E};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every load_pulse must match the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0 && load_pulse === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: port_in=%h at cycle %0d, expected no pulse", port_in, cyc);
      end else begin
        e = sb.pop_front();
        check("pulse_value", port_in, e.val);
        check("pulse_cycle", cyc, e.at);
      end
    end
  end

  initial begin
    reset    = 1'b1;
    sw       = '0;
    btn_load = 1'b0;
    cap_mode = 1'b0;
    disp_val = 16'hF810;
    tick(3);
    check("rst_port_in", port_in, 24'h0);
    check("rst_pulse", load_pulse, 1'b0);
    check("rst_an", an, 4'b1110);
    check("rst_seg", seg, 7'h7F);
    reset = 1'b0;

    // Test 4: scan walk and wrap
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      check("scan_an", an, AN_EXP[(k / 4) % 4]);
      check("scan_seg", seg, SEG_EXP[(k / 4) % 4]);
    end

    // Test 1: continuous capture
    sw = 12'h5A3;
    sb.push_back('{val: 24'h050A03, at: cyc + 3});
    tick(10);
    check("t1_port_in", port_in, 24'h050A03);

    // Test 2: strobed, bounce then real press
    cap_mode = 1'b1;
    tick(4);
    sw = 12'h123;
    tick(4);
    check("t2_hold", port_in, 24'h050A03);
    btn_load = 1'b1;
    tick(2);
    btn_load = 1'b0;
    tick(10);
    check("t2_bounce", port_in, 24'h050A03);
    btn_load = 1'b1;
    sb.push_back('{val: 24'h010203, at: cyc + 7});
    tick(10);
    btn_load = 1'b0;
    tick(12);
    check("t2_port_in", port_in, 24'h010203);

    // Test 3: strobed, switch change without press, then long press
    sw = 12'h9C7;
    tick(10);
    check("t3_hold", port_in, 24'h010203);
    btn_load = 1'b1;
    sb.push_back('{val: 24'h090C07, at: cyc + 7});
    tick(50);
    btn_load = 1'b0;
    tick(12);
    check("t3_port_in", port_in, 24'h090C07);

    // Test 6: strobed -> continuous
    sw = 12'hFFF;
    tick(5);
    check("t6_hold", port_in, 24'h090C07);
    cap_mode = 1'b0;
    sb.push_back('{val: 24'h0F0F0F, at: cyc + 3});
    tick(8);
    check("t6_port_in", port_in, 24'h0F0F0F);

    // Test 5: reset while debounce counter is at 2
    cap_mode = 1'b1;
    tick(4);
    sw = 12'h456;
    tick(4);
    btn_load = 1'b1;
    tick(5);
    reset    = 1'b1;
    btn_load = 1'b0;
    sw       = '0;
    #1;
    check("t5_rst_port_in", port_in, 24'h0);
    check("t5_rst_pulse", load_pulse, 1'b0);
    check("t5_rst_an", an, 4'b1110);
    check("t5_rst_seg", seg, 7'h7F);
    tick(2);
    reset = 1'b0;
    @(negedge clk);
    check("t5_an", an, 4'b1110);
    check("t5_seg", seg, 7'h40);
    tick(12);
    check("t5_port_in", port_in, 24'h0);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d pulses missing, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
